dsc_s2b_frame: RTL and testbench



---
 rtl/dsc_pkg.sv | 13 +
 rtl/dsc_s2b_frame_if.sv | 36 +++
 rtl/dsc_frame_ctr.sv | 26 ++
 rtl/dsc_s2b_frame.sv | 134 +++++++++++++
 tb/tb_dsc_s2b_frame.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsc_pkg.sv
// Shared constants and FSM state type for the DSC stochastic-to-binary frame receiver.
package dsc_pkg;

  localparam int unsigned SNG_WIDTH_D   = 4;
  localparam int unsigned STREAM_LOG2_D = 2 * SNG_WIDTH_D;
  localparam int unsigned FRAME_LEN_D   = 1 << STREAM_LOG2_D;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dsc_s2b_frame_if.sv
// Sample/result handshake bundle between a DSC stream source and dsc_s2b_frame.
interface dsc_s2b_frame_if
  import dsc_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 2 * SNG_WIDTH_D
);

  logic                 en;
  logic                 start;
  logic                 sn_in;
  logic [OUT_WIDTH-1:0] z;
  logic                 valid;
  logic                 busy;
  logic                 sat;

  modport master (
    output en,
    output start,
    output sn_in,
    input  z,
    input  valid,
    input  busy,
    input  sat
  );

  modport slave (
    input  en,
    input  start,
    input  sn_in,
    output z,
    output valid,
    output busy,
    output sat
  );

endinterface

// File: rtl/dsc_frame_ctr.sv
// Enable-qualified frame position counter; wraps to zero and flags the last position.
module dsc_frame_ctr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [WIDTH-1:0] pos_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
    end else if (clr) begin
      pos_q <= '0;
    end else if (en) begin
      pos_q <= pos_q + WIDTH'(1);
    end
  end

  assign last = (pos_q == '1);

endmodule

// File: rtl/dsc_s2b_frame.sv
// DSC stochastic-to-binary frame receiver: counts ones over 2^STREAM_LOG2 enabled samples.
// Optional DSC_S2B_SATURATE_EN clamps z to all-ones and raises sat on overflow.
module dsc_s2b_frame
  import dsc_pkg::*;
#(
  parameter int unsigned SNG_WIDTH   = SNG_WIDTH_D,
  parameter int unsigned STREAM_LOG2 = 2 * SNG_WIDTH,
  parameter int unsigned OUT_WIDTH   = 2 * SNG_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  dsc_s2b_frame_if.slave  bus
);

  localparam int unsigned CNT_W = STREAM_LOG2 + 1;

  state_t               state_q, state_d;
  logic                 last;
  logic                 clr;
  logic                 sample;
  logic                 final_smp;
  logic [CNT_W-1:0]     ones_q, ones_d;
  logic [CNT_W-1:0]     final_cnt;
  logic [OUT_WIDTH-1:0] z_q, z_d;
  logic                 valid_q;
`ifdef DSC_S2B_SATURATE_EN
  logic                 sat_q, sat_d;
`endif

  dsc_frame_ctr #(
    .WIDTH (STREAM_LOG2)
  ) u_frame_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (sample),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The position counter wraps on its own at frame end, so a back-to-back
  // start only needs the ones count cleared, not an explicit counter clear.
  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    sample    = 1'b0;
    final_smp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        sample    = bus.en;
        final_smp = bus.en && last;
        if (final_smp) begin
          state_d = bus.start ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign final_cnt = ones_q + CNT_W'(bus.sn_in);

  always_comb begin
    ones_d = ones_q;
    if (clr || final_smp) begin
      ones_d = '0;
    end else if (sample) begin
      ones_d = final_cnt;
    end
  end

  always_comb begin
    z_d = z_q;
`ifdef DSC_S2B_SATURATE_EN
    sat_d = sat_q;
`endif
    if (final_smp) begin
`ifdef DSC_S2B_SATURATE_EN
      if (|(final_cnt >> OUT_WIDTH)) begin
        z_d   = '1;
        sat_d = 1'b1;
      end else begin
        z_d   = OUT_WIDTH'(final_cnt);
        sat_d = 1'b0;
      end
`else
      z_d = OUT_WIDTH'(final_cnt);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q  <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      ones_q  <= ones_d;
      z_q     <= z_d;
      valid_q <= final_smp;
    end
  end

`ifdef DSC_S2B_SATURATE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign bus.sat = sat_q;
`else
  assign bus.sat = 1'b0;
`endif

  assign bus.z     = z_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q == RUN);

endmodule

// File: tb/tb_dsc_s2b_frame.sv
// Self-checking bench for dsc_s2b_frame: frame contents are modelled as bit arrays and
// the expected result is the population count of the frame.
module tb_dsc_s2b_frame;
  import dsc_pkg::*;

  localparam int FL = FRAME_LEN_D;
  localparam int OW = 2 * SNG_WIDTH_D;

  logic clk = 1'b0;
  logic rst;

  dsc_s2b_frame_if bus ();

  dsc_s2b_frame dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          vq_cyc[$];
  logic [OW-1:0] vq_z[$];
  logic        vq_sat[$];

  bit chk_busy   = 1'b0;
  bit arm_busy   = 1'b0;
  int busy_drops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      vq_cyc.push_back(cyc);
      vq_z.push_back(bus.z);
      vq_sat.push_back(bus.sat);
    end
    if (chk_busy && bus.busy !== 1'b1) busy_drops++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int count_ones(input bit b[FL]);
    int n = 0;
    for (int i = 0; i < FL; i++) n += int'(b[i]);
    return n;
  endfunction

  function automatic logic [OW-1:0] exp_z(input int n);
`ifdef DSC_S2B_SATURATE_EN
    if (n > (1 << OW) - 1) return '1;
    return OW'(n);
`else
    return OW'(n % (1 << OW));
`endif
  endfunction

  function automatic logic exp_sat(input int n);
`ifdef DSC_S2B_SATURATE_EN
    return n > (1 << OW) - 1;
`else
    return (n < 0);
`endif
  endfunction

  task automatic make_frame(input int k, output bit b[FL]);
    bit t;
    int j;
    for (int i = 0; i < FL; i++) b[i] = (i < k);
    for (int i = FL - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = b[i]; b[i] = b[j]; b[j] = t;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.start = 1'b0;
      bus.en    = 1'($urandom);
      bus.sn_in = 1'($urandom);
    end
  endtask

  task automatic pulse_start(output int t);
    step();
    bus.start = 1'b1;
    bus.sn_in = 1'b1;
    bus.en    = 1'($urandom);
    t = cyc;
  endtask

  // mode 0: no stalls; 1: 3 stall cycles at a random spot in every 16 samples; 2: random stalls
  task automatic drive_frame(input bit b[FL], input int mode, input bit start_last,
                             input bit noise, output int stalls);
    int off = 0;
    int k;
    stalls = 0;
    for (int i = 0; i < FL; i++) begin
      if (i % 16 == 0) off = $urandom_range(0, 15);
      k = 0;
      if (mode == 1 && (i % 16) == off) k = 3;
      if (mode == 2 && $urandom_range(0, 3) == 0) k = $urandom_range(1, 2);
      for (int s = 0; s < k; s++) begin
        step();
        bus.en    = 1'b0;
        bus.sn_in = 1'($urandom);
        bus.start = noise ? 1'($urandom) : 1'b0;
        if (arm_busy) chk_busy = 1'b1;
      end
      stalls += k;
      step();
      bus.en    = 1'b1;
      bus.sn_in = b[i];
      bus.start = (i == FL - 1) ? start_last : (noise ? 1'($urandom) : 1'b0);
      if (arm_busy) chk_busy = 1'b1;
    end
  endtask

  task automatic wait_valid(output int c, output logic [OW-1:0] zz, output logic ss,
                            output bit ok);
    ok = 1'b0; c = 0; zz = '0; ss = 1'b0;
    for (int n = 0; n < 700 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (vq_cyc.size() > 0) begin
        c  = vq_cyc.pop_front();
        zz = vq_z.pop_front();
        ss = vq_sat.pop_front();
        ok = 1'b1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.start = 1'b0; bus.sn_in = 1'b0;
    repeat (3) step();
    checks++; if (bus.z !== '0)     begin errors++; $display("FAIL reset_z got=%0h exp=0", bus.z); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.sat !== 1'b0)   begin errors++; $display("FAIL reset_sat got=%b exp=0", bus.sat); end
    rst = 1'b0;
    go_idle(3);
  endtask

  task automatic test_dsc_product(input int mode);
    bit b[FL];
    int n, t, st, c;
    logic [OW-1:0] zz;
    logic ss;
    bit ok;
    for (int i = 0; i < FL; i++) b[i] = ((i / 16) < 15) && ((i % 16) < 15);
    n = count_ones(b);
    pulse_start(t);
    drive_frame(b, mode, 1'b0, 1'b0, st);
    wait_valid(c, zz, ss, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL product_timeout mode=%0d got=no_valid exp=valid", mode);
    end else begin
      checks++; if (c - t != FL + 1 + st) begin errors++; $display("FAIL product_latency mode=%0d got=%0d exp=%0d", mode, c - t, FL + 1 + st); end
      checks++; if (zz !== exp_z(n)) begin errors++; $display("FAIL product_z mode=%0d got=%0d exp=%0d", mode, zz, exp_z(n)); end
      checks++; if (ss !== exp_sat(n)) begin errors++; $display("FAIL product_sat mode=%0d got=%b exp=%b", mode, ss, exp_sat(n)); end
    end
    go_idle(4);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL product_busy_after mode=%0d got=%b exp=0", mode, bus.busy); end
    checks++; if (vq_cyc.size() != 0) begin errors++; $display("FAIL product_extra_valid mode=%0d got=%0d exp=0", mode, vq_cyc.size()); end
    vq_cyc.delete(); vq_z.delete(); vq_sat.delete();
  endtask

  task automatic test_count(input int k, input int mode, input bit noise, input string tag);
    bit b[FL];
    int n, t, st, c;
    logic [OW-1:0] zz;
    logic ss;
    bit ok;
    make_frame(k, b);
    n = count_ones(b);
    pulse_start(t);
    drive_frame(b, mode, 1'b0, noise, st);
    wait_valid(c, zz, ss, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_timeout got=no_valid exp=valid", tag);
    end else begin
      checks++; if (c - t != FL + 1 + st) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", tag, c - t, FL + 1 + st); end
      checks++; if (zz !== exp_z(n)) begin errors++; $display("FAIL %s_z got=%0d exp=%0d", tag, zz, exp_z(n)); end
      checks++; if (ss !== exp_sat(n)) begin errors++; $display("FAIL %s_sat got=%b exp=%b", tag, ss, exp_sat(n)); end
    end
    go_idle(3);
    checks++; if (vq_cyc.size() != 0) begin errors++; $display("FAIL %s_extra_valid got=%0d exp=0", tag, vq_cyc.size()); end
    vq_cyc.delete(); vq_z.delete(); vq_sat.delete();
  endtask

  task automatic test_idle_ignored(input int n_last);
    go_idle(1);
    for (int i = 0; i < 12; i++) begin
      step();
      bus.start = 1'b0; bus.en = 1'b1; bus.sn_in = 1'b1;
    end
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    checks++; if (vq_cyc.size() != 0) begin errors++; $display("FAIL idle_valid got=%0d exp=0", vq_cyc.size()); end
    checks++; if (bus.z !== exp_z(n_last)) begin errors++; $display("FAIL idle_z_hold got=%0d exp=%0d", bus.z, exp_z(n_last)); end
    vq_cyc.delete(); vq_z.delete(); vq_sat.delete();
  endtask

  task automatic test_reset_midframe();
    int t;
    pulse_start(t);
    for (int i = 0; i < 100; i++) begin
      step();
      bus.start = 1'b0; bus.en = 1'b1; bus.sn_in = 1'($urandom);
    end
    step();
    rst = 1'b1; bus.en = 1'b1; bus.start = 1'b1; bus.sn_in = 1'b1;
    step();
    rst = 1'b0; bus.en = 1'b0; bus.start = 1'b0;
    checks++; if (bus.z !== '0)       begin errors++; $display("FAIL midrst_z got=%0d exp=0", bus.z); end
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", bus.valid); end
    checks++; if (bus.sat !== 1'b0)   begin errors++; $display("FAIL midrst_sat got=%b exp=0", bus.sat); end
    go_idle(5);
    checks++; if (vq_cyc.size() != 0) begin errors++; $display("FAIL midrst_extra_valid got=%0d exp=0", vq_cyc.size()); end
    vq_cyc.delete(); vq_z.delete(); vq_sat.delete();
    test_count($urandom_range(1, FL - 1), 0, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back(input int k1, input int k2);
    bit b1[FL];
    bit b2[FL];
    int n1, n2, t, st, c1, c2;
    logic [OW-1:0] z1, z2;
    logic s1, s2;
    bit ok1, ok2;
    make_frame(k1, b1);
    make_frame(k2, b2);
    n1 = count_ones(b1);
    n2 = count_ones(b2);
    busy_drops = 0;
    pulse_start(t);
    arm_busy = 1'b1;
    drive_frame(b1, 0, 1'b1, 1'b0, st);
    drive_frame(b2, 0, 1'b0, 1'b0, st);
    chk_busy = 1'b0; arm_busy = 1'b0;
    wait_valid(c1, z1, s1, ok1);
    wait_valid(c2, z2, s2, ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++; $display("FAIL b2b_timeout got=%0d_valids exp=2", int'(ok1) + int'(ok2));
    end else begin
      checks++; if (c1 - t != FL + 1) begin errors++; $display("FAIL b2b_latency1 got=%0d exp=%0d", c1 - t, FL + 1); end
      checks++; if (c2 - c1 != FL)    begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", c2 - c1, FL); end
      checks++; if (z1 !== exp_z(n1)) begin errors++; $display("FAIL b2b_z1 got=%0d exp=%0d", z1, exp_z(n1)); end
      checks++; if (z2 !== exp_z(n2)) begin errors++; $display("FAIL b2b_z2 got=%0d exp=%0d", z2, exp_z(n2)); end
    end
    checks++; if (busy_drops != 0) begin errors++; $display("FAIL b2b_busy_drop got=%0d exp=0", busy_drops); end
    go_idle(3);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after got=%b exp=0", bus.busy); end
    vq_cyc.delete(); vq_z.delete(); vq_sat.delete();
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.start = 1'b0; bus.sn_in = 1'b0;
    test_reset();
    test_dsc_product(0);
    test_count(0, 0, 1'b0, "zeros");
    test_count(1, 0, 1'b0, "single");
    test_dsc_product(1);
    test_reset_midframe();
    test_back_to_back(64, 200);
    test_count(FL, 0, 1'b0, "all_ones");
    test_count(10, 0, 1'b0, "ten_after_full");
    test_idle_ignored(10);
    for (int r = 0; r < 4; r++) test_count($urandom_range(0, FL), 2, 1'b1, "random");
    test_back_to_back($urandom_range(0, FL), $urandom_range(0, FL));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
